cpu_sequencer: RTL and testbench
================================

Name: cpu_sequencer

Overview:
Top-level instruction sequencer for the 8-bit CPU. It fetches 8-bit instructions from program memory over a req/ack handshake and decodes them. It then drives the register-file read ports, the external combinational ALU and the register-file write port through a fixed fetch/decode/read/execute/writeback schedule. It owns the program counter, the zero flag and the halt state.

Parameters:
PC_W, 8, program counter / memory address width; the PC wraps modulo 2^PC_W.
RESET_PC, 0, PC value loaded on reset.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  level/pulse; leaves IDLE when high; ignored in all other states.
mem_addr  output  PC_W  fetch address, equal to PC.
mem_req  output  1  fetch request; held high until mem_ack.
mem_ack  input  1  fetch complete; mem_rdata valid in the same cycle; ignored when mem_req=0.
mem_rdata  input  8  instruction byte.
rf_raddr_a  output  3  register-file read address A (instr[5:3]).
rf_raddr_b  output  3  register-file read address B (instr[2:0]).
rf_rdata_a  input  8  read data A; synchronous RF, valid 1 cycle after the address.
rf_rdata_b  input  8  read data B, same timing.
alu_op  output  2  00 ONE, 01 ADD, 10 SUB, 11 SWAP.
alu_a  output  8  latched operand A.
alu_b  output  8  latched operand B.
alu_y  input  8  combinational ALU result, same cycle.
rf_we  output  1  register write enable.
rf_waddr  output  3  write address.
rf_wdata  output  8  write data.
flag_zero  output  1  registered zero flag.
busy  output  1  high in every state except IDLE and HALT.
halted  output  1  high in HALT.

Behaviour:
- Instruction format: [7:6] op, [5:3] ra, [2:0] rb.
  - ONE: r[ra] <= r[rb]+1.
  - ADD: r[ra] <= r[ra]+r[rb].
  - SUB: r[ra] <= r[ra]-r[rb].
  - SWAP: exchange r[ra] and r[rb].
  - 0x00 is HALT.
- Arithmetic is mod 256; the ALU computes it, and the sequencer only sequences.
- States: IDLE, FETCH, DECODE, READ, EXEC, WB, WB2, HALT.
- IDLE: start=1 -> FETCH.
- FETCH: mem_req=1, mem_addr=PC. On mem_ack=1, latch instr_q=mem_rdata -> DECODE. Otherwise stay, with mem_req and mem_addr held stable.
- DECODE: instr_q==0x00 -> HALT. Otherwise drive rf_raddr_a/b from instr_q -> READ. The read addresses stay driven from instr_q in all states after FETCH.
- READ: latch a_q=rf_rdata_a, b_q=rf_rdata_b at the end of the cycle -> EXEC.
- EXEC: alu_op=instr_q[7:6], alu_a=a_q, alu_b=b_q.
  - Latch res_q=alu_y.
  - For ONE/ADD/SUB: flag_zero <= (alu_y==0).
  - For SWAP: flag_zero unchanged.
  - -> WB.
- WB: rf_we=1, rf_waddr=ra, rf_wdata = res_q (ONE/ADD/SUB) or b_q (SWAP).
  - SWAP -> WB2.
  - Otherwise PC <= PC+1 -> FETCH.
- WB2: rf_we=1, rf_waddr=rb, rf_wdata=a_q; PC <= PC+1 -> FETCH.
- HALT: absorbing state. PC does not advance, mem_req=0, rf_we=0, start is ignored. Only rst_n exits HALT.
- Latency with a zero-wait ack: 5 cycles per instruction from FETCH entry to the next FETCH; SWAP takes 6. Each wait cycle of mem_ack adds 1.
- rf_we is high for exactly 1 cycle per WB/WB2 and never in any other state.
- SWAP with ra==rb: both writes are still issued, and the register value is unchanged.
- PC wrap: PC=2^PC_W-1 increments to 0 with no error.
- Reset (rst_n low, any state, asynchronous) forces:
  - state=IDLE, PC=RESET_PC, instr_q/a_q/b_q/res_q=0.
  - mem_req=0, rf_we=0, flag_zero=0, busy=0, halted=0.
  - An in-flight write is aborted immediately.
- All outputs are decoded from registered state and latches only; there is no combinational path from any input to any output.

Decomposition:
- cpu_pkg holds:
  - op_t enum (OP_ONE, OP_ADD, OP_SUB, OP_SWAP).
  - seq_state_t enum (the 8 states).
  - INSTR_HALT=8'h00.
  - Field-extract functions get_op/get_ra/get_rb.
- One natural sub-module: instr_decode (combinational). instr_q in; op, ra, rb, is_halt, is_swap, writes_flag out.

Test Plan:
1. Reset: hold rst_n=0 mid-FETCH -> mem_req=0, rf_we=0, flag_zero=0, halted=0, busy=0, mem_addr=0.
2. ADD 0x4A, r1=5, r2=3, mem_ack in the same cycle as the request -> rf_we for 1 cycle, 4 cycles after FETCH entry, with waddr=1, wdata=8. flag_zero=0; mem_addr then =1.
3. SUB 0x8A, r1=3, r2=3 -> wdata=0x00 to r1, flag_zero=1. A following ADD 0x4A with r1=0, r2=1 -> flag_zero=0.
4. SWAP 0xCA, r1=0x11, r2=0x22 -> two consecutive rf_we cycles, (1,0x22) then (2,0x11). flag_zero unchanged; 6 cycles per instruction.
5. mem_ack delayed 3 cycles -> mem_req high for 4 cycles with mem_addr stable. Then instr 0x00 -> halted=1, busy=0, no rf_we, and mem_req stays 0 despite a start pulse.
6. rst_n pulsed low during WB of ADD -> rf_we drops the same cycle. After release and start, fetch resumes from mem_addr=0 with flag_zero=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and instruction field helpers for the 8-bit CPU sequencer.
package cpu_pkg;

  typedef enum logic [1:0] {
    OP_ONE  = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10,
    OP_SWAP = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_READ,
    ST_EXEC,
    ST_WB,
    ST_WB2,
    ST_HALT
  } seq_state_t;

  localparam logic [7:0] INSTR_HALT = 8'h00;

  function automatic op_t get_op(input logic [7:0] instr);
    return op_t'(instr[7:6]);
  endfunction

  function automatic logic [2:0] get_ra(input logic [7:0] instr);
    return instr[5:3];
  endfunction

  function automatic logic [2:0] get_rb(input logic [7:0] instr);
    return instr[2:0];
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational split of the latched instruction into op, register fields and class bits.
module instr_decode
  import cpu_pkg::*;
(
  input  logic [7:0] instr,
  output logic [1:0] op,
  output logic [2:0] ra,
  output logic [2:0] rb,
  output logic       is_halt,
  output logic       is_swap,
  output logic       writes_flag
);

  assign op          = get_op(instr);
  assign ra          = get_ra(instr);
  assign rb          = get_rb(instr);
  assign is_halt     = (instr == INSTR_HALT);
  assign is_swap     = (get_op(instr) == OP_SWAP);
  // SWAP only moves data, so it leaves the zero flag alone
  assign writes_flag = !is_swap;

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/decode/read/execute/writeback sequencer; owns PC, zero flag and halt state.
//   state  | meaning
//   IDLE   | waiting for start
//   FETCH  | mem_req high at PC until mem_ack
//   DECODE | halt check, RF read addresses presented
//   READ   | capture RF read data into a_q/b_q
//   EXEC   | capture ALU result, update zero flag
//   WB     | write r[ra]; SWAP continues to WB2
//   WB2    | SWAP second write r[rb]
//   HALT   | absorbing until reset
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [PC_W-1:0] mem_addr,
  output logic            mem_req,
  input  logic            mem_ack,
  input  logic [7:0]      mem_rdata,
  output logic [2:0]      rf_raddr_a,
  output logic [2:0]      rf_raddr_b,
  input  logic [7:0]      rf_rdata_a,
  input  logic [7:0]      rf_rdata_b,
  output logic [1:0]      alu_op,
  output logic [7:0]      alu_a,
  output logic [7:0]      alu_b,
  input  logic [7:0]      alu_y,
  output logic            rf_we,
  output logic [2:0]      rf_waddr,
  output logic [7:0]      rf_wdata,
  output logic            flag_zero,
  output logic            busy,
  output logic            halted
);

  seq_state_t      state, state_next;
  logic [PC_W-1:0] pc;
  logic [7:0]      instr_q, a_q, b_q, res_q;
  logic [1:0]      op;
  logic [2:0]      ra, rb;
  logic            is_halt, is_swap, writes_flag;

  instr_decode u_decode (
    .instr       (instr_q),
    .op          (op),
    .ra          (ra),
    .rb          (rb),
    .is_halt     (is_halt),
    .is_swap     (is_swap),
    .writes_flag (writes_flag)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (start) state_next = ST_FETCH;
      ST_FETCH:  if (mem_ack) state_next = ST_DECODE;
      ST_DECODE: state_next = is_halt ? ST_HALT : ST_READ;
      ST_READ:   state_next = ST_EXEC;
      ST_EXEC:   state_next = ST_WB;
      ST_WB:     state_next = is_swap ? ST_WB2 : ST_FETCH;
      ST_WB2:    state_next = ST_FETCH;
      ST_HALT:   state_next = ST_HALT;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      pc        <= RESET_PC;
      instr_q   <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      flag_zero <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        ST_FETCH: if (mem_ack) instr_q <= mem_rdata;
        ST_READ: begin
          a_q <= rf_rdata_a;
          b_q <= rf_rdata_b;
        end
        ST_EXEC: begin
          res_q <= alu_y;
          if (writes_flag) flag_zero <= (alu_y == 8'h00);
        end
        ST_WB:   if (!is_swap) pc <= pc + PC_W'(1);
        ST_WB2:  pc <= pc + PC_W'(1);
        default: ;
      endcase
    end
  end

  // Every output below depends only on registered state and latches
  assign mem_addr   = pc;
  assign mem_req    = (state == ST_FETCH);
  assign rf_raddr_a = ra;
  assign rf_raddr_b = rb;
  assign alu_op     = op;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign rf_we      = (state == ST_WB) || (state == ST_WB2);
  assign rf_waddr   = (state == ST_WB2) ? rb : ra;
  assign rf_wdata   = (state == ST_WB2) ? a_q : (is_swap ? b_q : res_q);
  assign busy       = (state != ST_IDLE) && (state != ST_HALT);
  assign halted     = (state == ST_HALT);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer with program memory, synchronous RF and ALU models.
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] mem_addr;
  logic       mem_req;
  logic       mem_ack = 1'b0;
  logic [7:0] mem_rdata = 8'h00;
  logic [2:0] rf_raddr_a, rf_raddr_b;
  logic [7:0] rf_rdata_a, rf_rdata_b;
  logic [1:0] alu_op;
  logic [7:0] alu_a, alu_b, alu_y;
  logic       rf_we;
  logic [2:0] rf_waddr;
  logic [7:0] rf_wdata;
  logic       flag_zero, busy, halted;

  always #5 clk = ~clk;

  cpu_sequencer #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mem_addr   (mem_addr),
    .mem_req    (mem_req),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .rf_raddr_a (rf_raddr_a),
    .rf_raddr_b (rf_raddr_b),
    .rf_rdata_a (rf_rdata_a),
    .rf_rdata_b (rf_rdata_b),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_y      (alu_y),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .flag_zero  (flag_zero),
    .busy       (busy),
    .halted     (halted)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Environment: program memory, synchronous register file, combinational ALU
  logic [7:0] prog [256];
  logic [7:0] rf [8];
  logic [7:0] load_vals [8];
  logic       do_load = 1'b0;
  int         cyc = 0;
  int         ack_delay = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (do_load) begin
      for (int i = 0; i < 8; i++) rf[i] <= load_vals[i];
    end else if (rf_we) begin
      rf[rf_waddr] <= rf_wdata;
    end
    rf_rdata_a <= rf[rf_raddr_a];
    rf_rdata_b <= rf[rf_raddr_b];
  end

  always_comb begin
    alu_y = 8'h00;
    case (alu_op)
      2'b00:   alu_y = alu_b + 8'd1;
      2'b01:   alu_y = alu_a + alu_b;
      2'b10:   alu_y = alu_a - alu_b;
      default: alu_y = alu_b;
    endcase
  end

  // Reference model and scoreboard
  typedef struct {
    logic [2:0] waddr;
    logic [7:0] wdata;
    int         at_cyc;
    logic       flag;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        cur;
  logic [7:0] ref_regs [8];
  logic       ref_flag;
  logic [7:0] exp_pc;
  logic [7:0] ins, ma, mb, my;
  int         wait_cnt = 0;
  int         req_len = 0;
  int         next_fetch = -1;
  logic       prev_req = 1'b0;
  logic [7:0] req_addr;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      next_fetch = -1;
      exp_pc = 8'h00;
      ref_flag = 1'b0;
      for (int i = 0; i < 8; i++) ref_regs[i] = load_vals[i];
      wait_cnt = 0;
      prev_req = 1'b0;
      mem_ack = 1'b0;
    end else begin
      if (mem_req) begin
        if (!prev_req) begin
          req_addr = mem_addr;
          req_len = 0;
          if (next_fetch >= 0) check_val("fetch_spacing", cyc, next_fetch);
          next_fetch = -1;
        end else begin
          check_val("addr_stable", mem_addr, req_addr);
        end
        req_len++;
        if (wait_cnt >= ack_delay) begin
          ins = prog[mem_addr];
          mem_ack = 1'b1;
          mem_rdata = ins;
          check_val("req_len", req_len, ack_delay + 1);
          check_val("fetch_addr", mem_addr, exp_pc);
          if (ins != 8'h00) begin
            ma = ref_regs[ins[5:3]];
            mb = ref_regs[ins[2:0]];
            if (ins[7:6] == 2'b11) begin
              exp_q.push_back('{ins[5:3], mb, cyc + 4, ref_flag});
              exp_q.push_back('{ins[2:0], ma, cyc + 5, ref_flag});
              ref_regs[ins[5:3]] = mb;
              ref_regs[ins[2:0]] = ma;
              next_fetch = cyc + 6;
            end else begin
              my = (ins[7:6] == 2'b00) ? mb + 8'd1 :
                   (ins[7:6] == 2'b01) ? ma + mb : ma - mb;
              ref_flag = (my == 8'h00);
              exp_q.push_back('{ins[5:3], my, cyc + 4, ref_flag});
              ref_regs[ins[5:3]] = my;
              next_fetch = cyc + 5;
            end
            exp_pc = exp_pc + 8'd1;
          end
        end else begin
          mem_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        mem_ack = 1'b0;
        wait_cnt = 0;
      end
      prev_req = mem_req;

      if (rf_we) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_we", 1, 0);
        end else begin
          cur = exp_q.pop_front();
          check_val("wb_addr", rf_waddr, cur.waddr);
          check_val("wb_data", rf_wdata, cur.wdata);
          check_val("wb_cycle", cyc, cur.at_cyc);
          check_val("wb_flag", flag_zero, cur.flag);
        end
      end
    end
  end

  task automatic reset_and_load();
    rst_n = 1'b0;
    do_load = 1'b1;
    @(negedge clk);
    @(negedge clk);
    do_load = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_halt(input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!halted) check_val("halt_timeout", 0, 1);
  endtask

  task automatic set_regs(input logic [7:0] r1, input logic [7:0] r2, input logic [7:0] r3,
                          input logic [7:0] r4, input logic [7:0] r5);
    load_vals[0] = 8'h00; load_vals[1] = r1; load_vals[2] = r2; load_vals[3] = r3;
    load_vals[4] = r4;    load_vals[5] = r5; load_vals[6] = 8'h66; load_vals[7] = 8'h77;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 256; i++) prog[i] = 8'h00;
    set_regs(8'd5, 8'd3, 8'h11, 8'd2, 8'h22);

    // Reset asserted while a fetch is waiting on a slow ack
    ack_delay = 100;
    reset_and_load();
    pulse_start();
    repeat (3) @(negedge clk);
    check_val("fetch_waiting", mem_req, 1);
    rst_n = 1'b0;
    #1;
    check_val("rst_mem_req", mem_req, 0);
    check_val("rst_rf_we", rf_we, 0);
    check_val("rst_flag", flag_zero, 0);
    check_val("rst_halted", halted, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_addr", mem_addr, 8'h00);

    // ADD, ONE, SUB to zero, SWAP, SWAP same register, ADD, HALT
    ack_delay = 0;
    prog[0] = 8'h4A; prog[1] = 8'h0C; prog[2] = 8'h8A; prog[3] = 8'hDD;
    prog[4] = 8'hC9; prog[5] = 8'h4A; prog[6] = 8'h00;
    @(negedge clk);
    reset_and_load();
    pulse_start();
    wait_halt(200);
    check_val("a_halted", halted, 1);
    check_val("a_busy", busy, 0);
    check_val("a_pending", exp_q.size(), 0);
    check_val("a_r1", rf[1], 8'd3);
    check_val("a_r2", rf[2], 8'd3);
    check_val("a_r3", rf[3], 8'h22);
    check_val("a_r4", rf[4], 8'd2);
    check_val("a_r5", rf[5], 8'h11);
    check_val("a_flag", flag_zero, 0);
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("a_halt_req", mem_req, 0);
    end
    start = 1'b0;
    check_val("a_halt_pc", mem_addr, 8'd6);

    // Slow ack (3 wait cycles), then HALT ignores start
    for (int i = 0; i < 256; i++) prog[i] = 8'h00;
    prog[0] = 8'h4A;
    ack_delay = 3;
    set_regs(8'd5, 8'd3, 8'h11, 8'd2, 8'h22);
    reset_and_load();
    pulse_start();
    wait_halt(200);
    check_val("b_halted", halted, 1);
    check_val("b_busy", busy, 0);
    check_val("b_r1", rf[1], 8'd8);
    check_val("b_flag", flag_zero, 0);
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("b_halt_req", mem_req, 0);
      check_val("b_halt_we", rf_we, 0);
    end
    start = 1'b0;
    check_val("b_halt_pc", mem_addr, 8'd1);

    // Reset during WB aborts the write
    ack_delay = 0;
    set_regs(8'd5, 8'd3, 8'h11, 8'd2, 8'h22);
    reset_and_load();
    pulse_start();
    n = 0;
    while (!rf_we && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val("c_we_seen", rf_we, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("c_abort_we", rf_we, 0);
    check_val("c_abort_busy", busy, 0);
    @(negedge clk);
    check_val("c_r1_kept", rf[1], 8'd5);

    prog[0] = 8'h8A; prog[1] = 8'h00;
    set_regs(8'd7, 8'd7, 8'h11, 8'd2, 8'h22);
    reset_and_load();
    check_val("c_flag_rst", flag_zero, 0);
    check_val("c_addr_rst", mem_addr, 8'h00);
    pulse_start();
    check_val("c_refetch_addr", mem_addr, 8'h00);
    wait_halt(100);
    check_val("c_r1", rf[1], 8'h00);
    check_val("c_flag", flag_zero, 1);
    check_val("c_pending", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
